// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 serial byte receiver. Samples the line at mid-bit, delivers
//             framed bytes with a one-cycle ready strobe, flags bad stop bits
//             and keeps a saturating framing-error count.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       i_CLK,
    input  logic       i_RST_N,
    input  logic       i_EN,
    input  logic       i_RXD,
    output logic [7:0] o_RX,
    output logic       o_RX_READY,
    output logic       o_FRAME_ERR,
    output logic       o_BUSY,
    output logic [7:0] o_ERR_CNT
);

    localparam int              c_CW      = $clog2(CLKS_PER_BIT);
    localparam int              c_HALF    = CLKS_PER_BIT / 2;
    localparam logic [c_CW-1:0] c_HALF_M1 = c_CW'(c_HALF - 1);
    localparam logic [c_CW-1:0] c_BIT_M1  = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_BREAK = 3'd4;

    logic            r_rx_meta;
    logic            r_rxs;
    logic            r_rxs_d;
    logic [1:0]      r_prime;
    logic [2:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic [7:0]      r_rx;
    logic            r_ready;
    logic            r_ferr;
    logic [7:0]      r_err_cnt;
    logic            w_primed;
    logic            w_start;

    // The sync flops reset high, so their first few values after reset are
    // not real line samples. r_prime counts until rxs_d holds a genuine
    // sample; until then no falling edge is believed. This keeps a line that
    // is held low across reset release from looking like a start bit.
    assign w_primed = (r_prime == 2'd3);
    assign w_start  = w_primed && r_rxs_d && !r_rxs;

    // Two-flop synchronizer, edge-detect delay and post-reset priming counter.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
            r_rxs_d   <= 1'b1;
            r_prime   <= 2'd0;
        end else begin
            r_rx_meta <= i_RXD;
            r_rxs     <= r_rx_meta;
            r_rxs_d   <= r_rxs;
            if (!w_primed) begin
                r_prime <= r_prime + 2'd1;
            end
        end
    end

    // Receive FSM: mid-bit sampling, byte assembly, strobes and error count.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_bit     <= 3'd0;
            r_shift   <= 8'h00;
            r_rx      <= 8'h00;
            r_ready   <= 1'b0;
            r_ferr    <= 1'b0;
            r_err_cnt <= 8'h00;
        end else begin
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
            if (!i_EN) begin
                // Drop any frame in progress; received byte and count persist.
                r_state <= c_ST_IDLE;
                r_cnt   <= '0;
                r_bit   <= 3'd0;
                r_shift <= 8'h00;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_start) begin
                            r_state <= c_ST_START;
                            r_cnt   <= '0;
                        end
                    end
                    c_ST_START: begin
                        if (r_cnt == c_HALF_M1) begin
                            r_cnt   <= '0;
                            r_bit   <= 3'd0;
                            r_state <= r_rxs ? c_ST_IDLE : c_ST_DATA;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    c_ST_DATA: begin
                        if (r_cnt == c_BIT_M1) begin
                            r_cnt   <= '0;
                            r_shift <= {r_rxs, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                            if (r_bit == 3'd7) begin
                                r_state <= c_ST_STOP;
                            end
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    c_ST_STOP: begin
                        if (r_cnt == c_BIT_M1) begin
                            r_cnt <= '0;
                            if (r_rxs) begin
                                // Leaving at mid-stop-bit lets a start bit
                                // that follows with no idle gap be caught.
                                r_rx    <= r_shift;
                                r_ready <= 1'b1;
                                r_state <= c_ST_IDLE;
                            end else begin
                                r_ferr <= 1'b1;
                                if (r_err_cnt != 8'hFF) begin
                                    r_err_cnt <= r_err_cnt + 8'd1;
                                end
                                r_state <= c_ST_BREAK;
                            end
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    c_ST_BREAK: begin
                        if (r_rxs) begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_RX        = r_rx;
    assign o_RX_READY  = r_ready;
    assign o_FRAME_ERR = r_ferr;
    assign o_BUSY      = (r_state != c_ST_IDLE);
    assign o_ERR_CNT   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx. Frames are generated as serial
//             waveforms; the expected strobe cycle, byte and error count of
//             every frame are predicted from bit timing arithmetic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB  = 8;
    localparam int HALF = CPB / 2;
    // Line fall placed just after edge C -> strobe visible after edge C+LAT:
    // 3 cycles to detection, half a bit to start sample, nine bits to stop.
    localparam int LAT  = 3 + HALF + 9 * CPB;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       rxd   = 1'b1;
    logic [7:0] o_rx;
    logic       o_ready;
    logic       o_ferr;
    logic       o_busy;
    logic [7:0] o_err;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_CLK      (clk),
        .i_RST_N    (rst_n),
        .i_EN       (en),
        .i_RXD      (rxd),
        .o_RX       (o_rx),
        .o_RX_READY (o_ready),
        .o_FRAME_ERR(o_ferr),
        .o_BUSY     (o_busy),
        .o_ERR_CNT  (o_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp_kind [int];   // 1 = good byte, 2 = framing error
    logic [7:0] exp_data [int];
    logic [7:0] m_rx  = 8'h00;
    logic [7:0] m_err = 8'h00;
    bit         chk_on = 1'b0;
    bit         e_r, e_f;
    int         ready_cyc [$];
    logic [7:0] ready_byte [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the predicted event schedule.
    always @(negedge clk) begin
        if (chk_on && rst_n) begin
            e_r = 1'b0;
            e_f = 1'b0;
            if (exp_kind.exists(cyc)) begin
                if (exp_kind[cyc] == 1) begin
                    e_r  = 1'b1;
                    m_rx = exp_data[cyc];
                end else begin
                    e_f = 1'b1;
                    if (m_err != 8'hFF) m_err = m_err + 8'd1;
                end
                exp_kind.delete(cyc);
                exp_data.delete(cyc);
            end
            check("rx_ready", o_ready, e_r);
            check("frame_err", o_ferr, e_f);
            check("rx_byte", o_rx, m_rx);
            check("err_cnt", o_err, m_err);
            if (o_ready) begin
                ready_cyc.push_back(cyc);
                ready_byte.push_back(o_rx);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame starting now. abort_off >= 0 drops i_EN at that
    // cycle offset into the frame (no event expected). brk extends a bad stop
    // bit with extra low cycles.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                              input int abort_off, input int brk);
        int   c0;
        logic v;
        c0 = cyc;
        if (abort_off < 0) begin
            exp_kind[c0 + LAT] = stop_ok ? 1 : 2;
            exp_data[c0 + LAT] = d;
        end
        for (int b = 0; b < 10; b++) begin
            if (b == 0)      v = 1'b0;
            else if (b == 9) v = stop_ok;
            else             v = d[b-1];
            for (int k = 0; k < CPB; k++) begin
                rxd = v;
                if (b * CPB + k == abort_off) en = 1'b0;
                tick();
            end
        end
        if (!stop_ok) begin
            rxd = 1'b0;
            repeat (brk) tick();
        end
        rxd = 1'b1;
    endtask

    task automatic model_reset();
        exp_kind.delete();
        exp_data.delete();
        m_rx  = 8'h00;
        m_err = 8'h00;
    endtask

    logic [7:0] b2b [6] = '{8'h20, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
    int         c0, nb;
    bit         good;

    initial begin
        // Reset values
        repeat (3) tick();
        check("rst_rx", o_rx, 8'h00);
        check("rst_ready", o_ready, 1'b0);
        check("rst_ferr", o_ferr, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_err", o_err, 8'h00);
        rst_n = 1'b1;
        en    = 1'b1;
        chk_on = 1'b1;
        repeat (5) tick();

        // Single frame 0x30, latency pinned by hand
        ready_cyc.delete();
        ready_byte.delete();
        c0 = cyc;
        send_frame(8'h30, 1'b1, -1, 0);
        repeat (5) tick();
        check("t1_count", ready_cyc.size(), 1);
        if (ready_cyc.size() > 0) begin
            check("t1_latency", ready_cyc[0] - c0, 79);
            check("t1_byte", ready_byte[0], 8'h30);
        end
        check("t1_err", o_err, 8'h00);

        // Six back-to-back frames with no idle gap
        ready_cyc.delete();
        ready_byte.delete();
        for (int i = 0; i < 6; i++) send_frame(b2b[i], 1'b1, -1, 0);
        repeat (5) tick();
        check("b2b_count", ready_cyc.size(), 6);
        for (int i = 0; i < ready_cyc.size() && i < 6; i++) begin
            check("b2b_byte", ready_byte[i], b2b[i]);
            if (i > 0) check("b2b_spacing", ready_cyc[i] - ready_cyc[i-1], 80);
        end

        // Two-cycle low glitch on idle line
        rxd = 1'b0;
        repeat (2) tick();
        rxd = 1'b1;
        nb = 0;
        repeat (12) begin
            tick();
            if (o_busy) nb++;
        end
        check("glitch_busy_le4", (nb >= 1 && nb <= 4), 1);
        check("glitch_idle", o_busy, 1'b0);

        // Bad stop bit with line held low, then a good frame
        send_frame(8'h55, 1'b0, -1, 30);
        check("break_busy", o_busy, 1'b1);
        repeat (4) tick();
        check("break_exit", o_busy, 1'b0);
        check("break_errcnt", o_err, 8'd1);
        check("break_rx_kept", o_rx, 8'h34);
        repeat (3) tick();
        send_frame(8'h31, 1'b1, -1, 0);
        repeat (3) tick();
        check("after_break_rx", o_rx, 8'h31);

        // Enable dropped at mid data bit 3
        send_frame(8'h33, 1'b1, 4 * CPB + HALF, 0);
        check("en_idle", o_busy, 1'b0);
        repeat (3) tick();
        en = 1'b1;
        repeat (5) tick();
        check("en_rx_kept", o_rx, 8'h31);
        check("en_err_kept", o_err, 8'd1);

        // Randomized frames against the timing model
        for (int i = 0; i < 40; i++) begin
            good = ($urandom_range(0, 9) < 8);
            send_frame(8'($urandom), good, -1, $urandom_range(4, 20));
            if (good) repeat ($urandom_range(0, 12)) tick();
            else      repeat ($urandom_range(2, 12)) tick();
        end
        repeat (LAT + 5) tick();

        // Reset asserted mid-frame
        rxd = 1'b0;
        repeat (20) tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rx", o_rx, 8'h00);
        check("mid_rst_ready", o_ready, 1'b0);
        check("mid_rst_ferr", o_ferr, 1'b0);
        check("mid_rst_busy", o_busy, 1'b0);
        check("mid_rst_err", o_err, 8'h00);
        model_reset();
        rxd = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();

        // Line held low across reset release
        rxd = 1'b0;
        tick();
        rst_n = 1'b0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (10) tick();
            check("held_low_idle", o_busy, 1'b0);
        end
        rxd = 1'b1;
        repeat (4) tick();
        send_frame(8'h31, 1'b1, -1, 0);
        repeat (3) tick();
        check("held_low_then_rx", o_rx, 8'h31);

        // Error counter saturation
        for (int i = 0; i < 257; i++) begin
            send_frame(8'($urandom), 1'b0, -1, 4);
            repeat (2) tick();
        end
        repeat (5) tick();
        check("sat_255", o_err, 8'd255);
        send_frame(8'hA5, 1'b1, -1, 0);
        repeat (3) tick();
        check("sat_good_rx", o_rx, 8'hA5);
        check("sat_hold", o_err, 8'd255);

        repeat (20) tick();
        check("pending_events", exp_kind.num(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
